// File: rtl/mem_burst_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_burst_arbiter.
// Requests are level-held: reqN is sampled only in IDLE, and wr/addr/len are sampled at the grant edge.
// Beats are not back-pressured: wr_strobeN or rvalidN marks one beat per cycle, and doneN ends the burst.
interface mem_burst_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic              req0, req1;
    logic              wr0, wr1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [LEN_W-1:0]  len0, len1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              wr_strobe0, wr_strobe1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              rvalid0, rvalid1;
    logic              done0, done1;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read_signal, mem_write_signal;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_dataout;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, len0, len1, wdata0, wdata1, mem_dataout,
        output wr_strobe0, wr_strobe1, rdata0, rdata1, rvalid0, rvalid1, done0, done1, busy,
               mem_address, mem_read_signal, mem_write_signal, mem_data
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, len0, len1, wdata0, wdata1, mem_dataout,
        input  wr_strobe0, wr_strobe1, rdata0, rdata1, rvalid0, rvalid1, done0, done1, busy,
               mem_address, mem_read_signal, mem_write_signal, mem_data
    );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Round-robin two-requester arbiter that sequences byte-wide read/write bursts
// onto the shared feature/weight memory, one beat per cycle.
module mem_burst_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                RST,
    mem_burst_arbiter_if.slave  bus,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               gnt, last;
    logic [LEN_W-1:0]   cnt;
    logic [ADDR_W-1:0]  mem_address_q;
    logic               mem_rd_q, mem_wr_q;
    logic [DATA_W-1:0]  rdata0_q, rdata1_q;
    logic               rvalid0_q, rvalid1_q;

    logic               arb_valid, arb_sel, arb_wr;
    logic [ADDR_W-1:0]  arb_addr;
    logic [LEN_W-1:0]   arb_len;

    // On a tie the requester that did not win last time takes the grant.
    always_comb begin
        arb_valid = bus.req0 | bus.req1;
        arb_sel   = (bus.req0 & bus.req1) ? ~last : bus.req1;
        arb_wr    = arb_sel ? bus.wr1   : bus.wr0;
        arb_addr  = arb_sel ? bus.addr1 : bus.addr0;
        arb_len   = arb_sel ? bus.len1  : bus.len0;
    end

    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arb_valid) state_next = (arb_len == '0) ? DRAIN : BURST;
            BURST:   if (cnt == LEN_W'(1)) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            gnt           <= 1'b0;
            last          <= 1'b1;
            cnt           <= '0;
            mem_address_q <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        gnt  <= arb_sel;
                        last <= arb_sel;
                        cnt  <= arb_len;
                        if (arb_len != '0) begin
                            mem_address_q <= arb_addr;
                            mem_rd_q      <= ~arb_wr;
                            mem_wr_q      <= arb_wr;
                        end
                    end
                end
                BURST: begin
                    cnt <= cnt - LEN_W'(1);
                    // The final beat drops the command at the same edge the FSM enters DRAIN.
                    if (cnt == LEN_W'(1)) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                    end else begin
                        mem_address_q <= mem_address_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase

            // Read data is captured at the end of the issuing cycle and is valid one cycle later.
            rvalid0_q <= mem_rd_q & ~gnt;
            rvalid1_q <= mem_rd_q & gnt;
            if (mem_rd_q) begin
                if (gnt) rdata1_q <= bus.mem_dataout;
                else     rdata0_q <= bus.mem_dataout;
            end
        end
    end

    assign bus.mem_address      = mem_address_q;
    assign bus.mem_read_signal  = mem_rd_q;
    assign bus.mem_write_signal = mem_wr_q;
    assign bus.mem_data         = gnt ? bus.wdata1 : bus.wdata0;
    assign bus.wr_strobe0       = mem_wr_q & ~gnt;
    assign bus.wr_strobe1       = mem_wr_q & gnt;
    assign bus.rdata0           = rdata0_q;
    assign bus.rdata1           = rdata1_q;
    assign bus.rvalid0          = rvalid0_q;
    assign bus.rvalid1          = rvalid1_q;
    assign bus.done0            = (state == DRAIN) & ~gnt;
    assign bus.done1            = (state == DRAIN) & gnt;
    assign bus.busy             = (state != IDLE);
    assign state_dbg            = state;
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter: a byte memory model plus an event scoreboard
// where each expected event carries its cycle offset within the burst.
module tb_mem_burst_arbiter;
    localparam logic [1:0] K_R = 2'd0, K_W = 2'd1, K_V = 2'd2, K_D = 2'd3;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] state_dbg;

    mem_burst_arbiter_if #(.ADDR_W(16), .DATA_W(8), .LEN_W(8)) bus ();

    mem_burst_arbiter #(.ADDR_W(16), .DATA_W(8), .LEN_W(8)) dut (
        .clk       (clk),
        .RST       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    logic [35:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [7:0] vec   [0:15];
    logic [7:0] wbuf0 [0:15];
    logic [7:0] wbuf1 [0:15];
    int wi0 = 0;
    int wi1 = 0;
    logic [7:0] mem [0:65535];

    // Event word: kind, who (one-hot requester bits), cycle offset in burst, address, data.
    function automatic logic [35:0] ev(input logic [1:0] kind, input logic [1:0] who,
                                       input logic [7:0] idx, input logic [15:0] a,
                                       input logic [7:0] d);
        return {kind, who, idx, a, d};
    endfunction

    task automatic sb_check(input string name, input logic [35:0] act);
        logic [35:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event got=%h expected=none", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got=%h expected=%h", name, act, exp);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected events for one burst, in the per-cycle order the monitor reports them.
    task automatic push_burst(input bit r, input bit wr, input logic [15:0] base, input int len);
        logic [1:0] who;
        who = r ? 2'b10 : 2'b01;
        for (int k = 0; k <= len; k++) begin
            if (k < len) begin
                if (wr) exp_q.push_back(ev(K_W, who, 8'(k), base + 16'(k), vec[k]));
                else    exp_q.push_back(ev(K_R, 2'b00, 8'(k), base + 16'(k), 8'h00));
            end
            if (!wr && k > 0) exp_q.push_back(ev(K_V, who, 8'(k), 16'h0000, vec[k-1]));
            if (k == len)     exp_q.push_back(ev(K_D, who, 8'(k), 16'h0000, 8'h00));
        end
    endtask

    task automatic set_vec(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
    endtask

    task automatic issue(input bit r, input bit wr, input logic [15:0] a, input logic [7:0] l);
        if (r) begin
            bus.wr1 = wr; bus.addr1 = a; bus.len1 = l; bus.req1 = 1'b1;
        end else begin
            bus.wr0 = wr; bus.addr0 = a; bus.len0 = l; bus.req0 = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
        end while (bus.busy && c < 100);
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL wait_idle: busy got=1 expected=0 after %0d cycles", c);
        end
    endtask

    // Requests are dropped in the DRAIN cycle of the n-th completion.
    task automatic wait_done(input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < 400 && seen < n; c++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) seen++;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL wait_done: done pulses got=%0d expected=%0d", seen, n);
        end
    endtask

    initial begin
        bus.mem_dataout = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_write_signal) mem[bus.mem_address] = bus.mem_data;
            if (bus.mem_read_signal)  bus.mem_dataout = mem[bus.mem_address];
        end
    end

    initial begin
        logic s0, s1;
        forever begin
            @(negedge clk);
            s0 = bus.wr_strobe0;
            s1 = bus.wr_strobe1;
            @(posedge clk); #1;
            if (s0) begin wi0 = wi0 + 1; bus.wdata0 = wbuf0[wi0 & 15]; end
            if (s1) begin wi1 = wi1 + 1; bus.wdata1 = wbuf1[wi1 & 15]; end
        end
    end

    initial begin
        int idx;
        logic [7:0] cur;
        idx = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy) idx = 0;
            cur = idx[7:0];
            if (bus.mem_write_signal || bus.wr_strobe0 || bus.wr_strobe1) begin
                chk("cmd_overlap", {31'd0, bus.mem_read_signal & bus.mem_write_signal}, 32'd0);
                sb_check("write_beat", ev(K_W, {bus.wr_strobe1, bus.wr_strobe0}, cur,
                                          bus.mem_address, bus.mem_data));
            end else if (bus.mem_read_signal) begin
                sb_check("read_cmd", ev(K_R, 2'b00, cur, bus.mem_address, 8'h00));
            end
            if (bus.rvalid0 || bus.rvalid1)
                sb_check("read_data", ev(K_V, {bus.rvalid1, bus.rvalid0}, cur, 16'h0000,
                                         bus.rvalid1 ? bus.rdata1 : bus.rdata0));
            if (bus.done0 || bus.done1)
                sb_check("done", ev(K_D, {bus.done1, bus.done0}, cur, 16'h0000, 8'h00));
            if (bus.busy) idx++;
        end
    end

    initial begin
        rst = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.len0 = 0; bus.len1 = 0;
        bus.wdata0 = 0; bus.wdata1 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_cmd", {30'd0, bus.mem_read_signal, bus.mem_write_signal}, 32'd0);
        chk("reset_addr", {16'd0, bus.mem_address}, 32'd0);
        chk("reset_rdata", {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
        chk("reset_flags", {26'd0, bus.rvalid0, bus.rvalid1, bus.done0, bus.done1,
                            bus.wr_strobe0, bus.wr_strobe1}, 32'd0);

        // Test 1: write AA..DD to 0x0100 from requester 0
        wait_idle();
        set_vec(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        for (int i = 0; i < 4; i++) wbuf0[i] = vec[i];
        wi0 = 0; bus.wdata0 = wbuf0[0];
        push_burst(0, 1, 16'h0100, 4);
        issue(0, 1, 16'h0100, 8'd4);
        wait_done(1);

        // Test 2: requester 1 reads them back
        wait_idle();
        push_burst(1, 0, 16'h0100, 4);
        issue(1, 0, 16'h0100, 8'd4);
        wait_done(1);

        // Test 3: simultaneous held requests alternate 0,1,0,1
        wait_idle();
        wbuf1[0] = 8'h11; wbuf1[1] = 8'h22; wbuf1[2] = 8'h33; wbuf1[3] = 8'h44;
        wi1 = 0; bus.wdata1 = wbuf1[0];
        set_vec(8'hAA, 8'hBB, 8'h00, 8'h00); push_burst(0, 0, 16'h0100, 2);
        set_vec(8'h11, 8'h22, 8'h00, 8'h00); push_burst(1, 1, 16'h0200, 2);
        set_vec(8'hAA, 8'hBB, 8'h00, 8'h00); push_burst(0, 0, 16'h0100, 2);
        set_vec(8'h33, 8'h44, 8'h00, 8'h00); push_burst(1, 1, 16'h0200, 2);
        issue(0, 0, 16'h0100, 8'd2);
        issue(1, 1, 16'h0200, 8'd2);
        wait_done(4);

        // Test 4: address wrap at the top of memory
        wait_idle();
        set_vec(8'h01, 8'h02, 8'h03, 8'h00);
        for (int i = 0; i < 4; i++) wbuf0[i] = vec[i];
        wi0 = 0; bus.wdata0 = wbuf0[0];
        push_burst(0, 1, 16'hFFFE, 3);
        issue(0, 1, 16'hFFFE, 8'd3);
        wait_done(1);

        // Test 5: zero-length burst gives only a done pulse
        wait_idle();
        push_burst(0, 0, 16'h0300, 0);
        issue(0, 0, 16'h0300, 8'd0);
        wait_done(1);

        // Test 6: reset during beat 2 of an 8-beat read from requester 1
        wait_idle();
        exp_q.push_back(ev(K_R, 2'b00, 8'd0, 16'h0100, 8'h00));
        exp_q.push_back(ev(K_R, 2'b00, 8'd1, 16'h0101, 8'h00));
        exp_q.push_back(ev(K_V, 2'b10, 8'd1, 16'h0000, 8'hAA));
        exp_q.push_back(ev(K_R, 2'b00, 8'd2, 16'h0102, 8'h00));
        exp_q.push_back(ev(K_V, 2'b10, 8'd2, 16'h0000, 8'hBB));
        issue(1, 0, 16'h0100, 8'd8);
        @(posedge clk); #1 bus.req1 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_read_cmd", {31'd0, bus.mem_read_signal}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        set_vec(8'hAA, 8'h00, 8'h00, 8'h00);
        push_burst(0, 0, 16'h0100, 1);
        push_burst(1, 0, 16'h0100, 1);
        issue(0, 0, 16'h0100, 8'd1);
        issue(1, 0, 16'h0100, 8'd1);
        wait_done(2);

        repeat (5) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
